// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_sequencer
// Description : Walks a small table of fixed-length SPI commands and drives
//               an external SPI master through a reset / load / send
//               handshake for each one. Idle gap cycles separate frames.
//               A per-step wait timeout aborts the sequence with a sticky
//               error flag.
// Ports       : i_Clk, i_Rst_n           clock, async active-low reset
//               i_Start, i_Num_Cmds      sequence start pulse and length
//               i_Cmd_Wr_*               command table write port
//               i_SPI_StatusReg/RW       completion status from SPI master
//               i_Tx_Cnt                 SPI master loaded-byte count
//               o_StatusReg, o_TxBuffer  control word and byte to SPI master
//               o_Cmd_Lim, o_Cmd_Idx     frame length and active command
//               o_Busy, o_Done, o_Error  sequence status
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_sequencer #(
    parameter int NUM_CMDS      = 8,
    parameter int BYTES_PER_CMD = 3,
    parameter int GAP_CYCLES    = 21,
    parameter int TIMEOUT       = 65535
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    input  logic [3:0]  i_Num_Cmds,
    input  logic        i_Cmd_Wr_En,
    input  logic [2:0]  i_Cmd_Wr_Addr,
    input  logic [24:0] i_Cmd_Wr_Data,
    input  logic [7:0]  i_SPI_StatusReg,
    input  logic        i_SPI_StatusRW,
    input  logic [7:0]  i_Tx_Cnt,
    output logic [7:0]  o_StatusReg,
    output logic [7:0]  o_TxBuffer,
    output logic [7:0]  o_Cmd_Lim,
    output logic [2:0]  o_Cmd_Idx,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Error
);

    localparam int c_CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [7:0]         c_BYTE_LAST = 8'(BYTES_PER_CMD - 1);
    localparam logic [3:0]         c_NUM_MAX   = 4'(NUM_CMDS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST       = 3'd1,
        S_LOAD      = 3'd2,
        S_LOAD_WAIT = 3'd3,
        S_SEND      = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_GAP       = 3'd6,
        S_FINISH    = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           cmd_idx_q, cmd_idx_d;
    logic [7:0]           byte_idx_q, byte_idx_d;
    logic [7:0]           exp_cnt_q, exp_cnt_d;
    logic [c_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]           txbuf_q, txbuf_d;
    logic                 rx_q, rx_d;
    logic [3:0]           num_q, num_d;
    logic                 error_q, error_d;
    logic                 abort_q, abort_d;
    logic                 zdone_q, zdone_d;
    logic [24:0]          tbl_q [0:7];

    logic [24:0]          w_entry;
    logic [23:0]          w_shifted;
    logic [7:0]           w_byte;
    logic [3:0]           w_num_clamped;
    logic                 w_last_cmd;
    logic                 w_spi_done;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // Command table: writable in every state, read live at each LOAD so a
    // rewrite of the active entry shows up at the next byte load.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < 8; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (i_Cmd_Wr_En && ({1'b0, i_Cmd_Wr_Addr} < c_NUM_MAX)) begin
            tbl_q[i_Cmd_Wr_Addr] <= i_Cmd_Wr_Data;
        end
    end

    assign w_entry       = tbl_q[cmd_idx_q];
    // Byte 0 is the most significant byte of the frame.
    assign w_shifted     = w_entry[23:0] >> (8 * (BYTES_PER_CMD - 1 - int'(byte_idx_q)));
    assign w_byte        = w_shifted[7:0];
    assign w_num_clamped = (i_Num_Cmds > c_NUM_MAX) ? c_NUM_MAX : i_Num_Cmds;
    assign w_last_cmd    = ({1'b0, cmd_idx_q} == (num_q - 4'd1));
    assign w_spi_done    = i_SPI_StatusReg[7] & i_SPI_StatusRW;
    assign w_unused      = ^{i_SPI_StatusReg[6:0], w_shifted[23:8]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            cmd_idx_q  <= '0;
            byte_idx_q <= '0;
            exp_cnt_q  <= '0;
            wait_cnt_q <= '0;
            txbuf_q    <= '0;
            rx_q       <= 1'b0;
            num_q      <= '0;
            error_q    <= 1'b0;
            abort_q    <= 1'b0;
            zdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_idx_q  <= cmd_idx_d;
            byte_idx_q <= byte_idx_d;
            exp_cnt_q  <= exp_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            txbuf_q    <= txbuf_d;
            rx_q       <= rx_d;
            num_q      <= num_d;
            error_q    <= error_d;
            abort_q    <= abort_d;
            zdone_q    <= zdone_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cmd_idx_d  = cmd_idx_q;
        byte_idx_d = byte_idx_q;
        exp_cnt_d  = exp_cnt_q;
        txbuf_d    = txbuf_q;
        rx_d       = rx_q;
        num_d      = num_q;
        error_d    = error_q;
        abort_d    = 1'b0;
        zdone_d    = 1'b0;
        wait_cnt_d = wait_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    if (w_num_clamped != 4'd0) begin
                        state_d    = S_RST;
                        error_d    = 1'b0;
                        cmd_idx_d  = '0;
                        byte_idx_d = '0;
                        num_d      = w_num_clamped;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            S_RST: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // The master bumps its count once it has taken the byte.
                txbuf_d   = w_byte;
                rx_d      = w_entry[24];
                exp_cnt_d = i_Tx_Cnt + 8'd1;
                state_d   = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                if (i_Tx_Cnt == exp_cnt_q) begin
                    if (byte_idx_q < c_BYTE_LAST) begin
                        byte_idx_d = byte_idx_q + 8'd1;
                        state_d    = S_LOAD;
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (wait_cnt_q == c_TO_LAST) begin
                    error_d = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // The master's status is still stale in the first cycle
                // after SEND, so completion is only honoured from then on.
                if (w_spi_done && (wait_cnt_q != '0)) begin
                    state_d = w_last_cmd ? S_FINISH : S_GAP;
                end else if (wait_cnt_q == c_TO_LAST) begin
                    error_d = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (wait_cnt_q == c_GAP_LAST) begin
                    cmd_idx_d  = cmd_idx_q + 3'd1;
                    byte_idx_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            wait_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_StatusReg = 8'h00;
        case (state_q)
            S_IDLE:      o_StatusReg = abort_q ? 8'h01 : 8'h00;
            S_RST:       o_StatusReg = 8'h01;
            S_LOAD:      o_StatusReg = 8'h02;
            S_SEND:      o_StatusReg = {4'b0000, 1'b1, rx_q, 2'b00};
            S_WAIT_DONE: o_StatusReg = {5'b00000, rx_q, 2'b00};
            default:     o_StatusReg = 8'h00;
        endcase
    end

    assign o_TxBuffer = (state_q == S_LOAD) ? w_byte : txbuf_q;
    assign o_Cmd_Lim  = 8'(BYTES_PER_CMD);
    assign o_Cmd_Idx  = cmd_idx_q;
    assign o_Busy     = (state_q != S_IDLE);
    assign o_Done     = (state_q == S_FINISH) | zdone_q;
    assign o_Error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_sequencer
// Description : Self-checking bench for spi_cmd_sequencer. A simple SPI
//               master model acknowledges byte loads and sends after random
//               delays; expected control words, bytes and timing are derived
//               from a bench-side copy of the command table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_sequencer;

    localparam int TO  = 200;
    localparam int GAP = 21;
    localparam int BPC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  num = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [24:0] wr_data = '0;
    logic [7:0]  spi_stat = '0;
    logic        spi_rw = 1'b0;
    logic [7:0]  tx_cnt = '0;
    logic [7:0]  stat, txb, lim;
    logic [2:0]  idx;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [24:0] mtbl [8];

    spi_cmd_sequencer #(
        .NUM_CMDS      (8),
        .BYTES_PER_CMD (BPC),
        .GAP_CYCLES    (GAP),
        .TIMEOUT       (TO)
    ) dut (
        .i_Clk           (clk),
        .i_Rst_n         (rst_n),
        .i_Start         (start),
        .i_Num_Cmds      (num),
        .i_Cmd_Wr_En     (wr_en),
        .i_Cmd_Wr_Addr   (wr_addr),
        .i_Cmd_Wr_Data   (wr_data),
        .i_SPI_StatusReg (spi_stat),
        .i_SPI_StatusRW  (spi_rw),
        .i_Tx_Cnt        (tx_cnt),
        .o_StatusReg     (stat),
        .o_TxBuffer      (txb),
        .o_Cmd_Lim       (lim),
        .o_Cmd_Idx       (idx),
        .o_Busy          (busy),
        .o_Done          (done),
        .o_Error         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance to the next sampling point; table strobes last one edge.
    task automatic step();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [24:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mtbl[a] = d;
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            write_entry(3'(i), 25'($urandom));
            step();
        end
    endtask

    // mode 0: normal run, 1: master never loads (timeout), 2: reset mid-load
    task automatic run_seq(input int n_req, input int mode);
        int n, dly, a, e, d0;
        logic [24:0] ent;
        logic [7:0]  byte_e;
        logic        rx;
        n  = (n_req > 8) ? 8 : n_req;
        d0 = done_cnt;
        rx = 1'b0;
        num = 4'(n_req);
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_stat", stat, 32'h01);
        check("rst_busy", busy, 1);
        check("start_err_clr", err, 0);
        for (int c = 0; c < n; c++) begin
            for (int b = 0; b < BPC; b++) begin
                step();
                ent    = mtbl[c];
                byte_e = 8'(ent[23:0] >> (8 * (BPC - 1 - b)));
                rx     = ent[24];
                check("load_stat", stat, 32'h02);
                check("load_byte", txb, byte_e);
                check("cmd_idx", idx, c);
                if (mode == 1 && c == 0 && b == 1) begin
                    for (int k = 0; k < TO; k++) begin
                        step();
                        check("stall_stat", stat, 0);
                    end
                    step();
                    check("to_stat", stat, 32'h01);
                    check("to_err", err, 1);
                    check("to_busy", busy, 0);
                    check("to_done", done, 0);
                    step();
                    check("to_stat_end", stat, 0);
                    check("to_err_sticky", err, 1);
                    check("to_no_done", done_cnt, d0);
                    return;
                end
                dly = $urandom_range(1, 4);
                for (int k = 0; k < dly; k++) begin
                    step();
                    if (mode == 2 && c == 0 && b == 1) begin
                        #1 rst_n = 1'b0;
                        #1;
                        check("arst_stat", stat, 0);
                        check("arst_txb", txb, 0);
                        check("arst_idx", idx, 0);
                        check("arst_busy", busy, 0);
                        check("arst_done", done, 0);
                        check("arst_err", err, 0);
                        step();
                        step();
                        rst_n = 1'b1;
                        for (int i = 0; i < 8; i++) mtbl[i] = '0;
                        check("arst_no_done", done_cnt, d0);
                        return;
                    end
                    check("wait_stat", stat, 0);
                    check("txbuf_hold", txb, byte_e);
                    if (k == 0 && $urandom_range(0, 2) == 0)
                        write_entry(3'($urandom_range(0, 7)), 25'($urandom));
                    if (k == dly - 1) tx_cnt = tx_cnt + 8'd1;
                end
            end
            step();
            check("send_stat", stat, {4'b0000, 1'b1, rx, 2'b00});
            a = $urandom_range(0, 4);
            if (a == 0) begin
                spi_stat = 8'h80;
                spi_rw   = 1'b1;
            end
            e = (a < 2) ? 2 : a;
            for (int j = 1; j <= e; j++) begin
                step();
                check("wd_stat", stat, {5'b00000, rx, 2'b00});
                if (j == a) begin
                    spi_stat = 8'h80;
                    spi_rw   = 1'b1;
                end
                if (j == 1) start = 1'($urandom_range(0, 1));
                if (j == 2) start = 1'b0;
            end
            step();
            spi_stat = 8'h00;
            spi_rw   = 1'b0;
            if (c == n - 1) begin
                check("done_pulse", done, 1);
                step();
                check("done_end", done, 0);
                check("idle_busy", busy, 0);
                check("one_done", done_cnt, d0 + 1);
            end else begin
                check("gap_stat", stat, 0);
                check("gap_done", done, 0);
                for (int g = 1; g < GAP; g++) begin
                    step();
                    check("gap_stat", stat, 0);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mtbl[i] = '0;
        tx_cnt = 8'($urandom);
        repeat (3) @(negedge clk);
        check("reset_stat", stat, 0);
        check("reset_txb", txb, 0);
        check("reset_idx", idx, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("cmd_lim", lim, BPC);
        rst_n = 1'b1;
        step();

        write_entry(3'd0, 25'h00A1234);
        step();
        run_seq(1, 0);

        load_table();
        run_seq(3, 0);

        write_entry(3'd0, {1'b1, 24'($urandom)});
        step();
        run_seq(1, 0);

        run_seq(1, 1);
        run_seq(2, 0);

        run_seq(2, 2);
        write_entry(3'd1, 25'($urandom));
        step();
        run_seq(2, 0);

        num   = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_stat", stat, 0);
        check("zero_busy", busy, 0);
        step();
        check("zero_done_end", done, 0);
        check("zero_stat_end", stat, 0);

        load_table();
        run_seq(12, 0);
        repeat (4) run_seq($urandom_range(1, 8), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_CMDS, 8, command table depth.
- BYTES_PER_CMD, 3, bytes per SPI frame, driven as o_Cmd_Lim.
- GAP_CYCLES, 21, idle cycles between frames.
- TIMEOUT, 65535, maximum wait cycles per handshake step.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports, one per line (name, direction, width, meaning):
- i_Clk, in, 1, FPGA clock.
- i_Rst_n, in, 1, async active-low reset.
- i_Start, in, 1, pulse that starts the sequence.
- i_Num_Cmds, in, 4, commands to run (0 = none).
- i_Cmd_Wr_En, in, 1, table write strobe.
- i_Cmd_Wr_Addr, in, 3, table index.
- i_Cmd_Wr_Data, in, 25, bit24 = receive flag, [23:0] = bytes MSB-first.
- i_SPI_StatusReg, in, 8, status from the SPI master.
- i_SPI_StatusRW, in, 1, SPI master idle/accept indicator.
- i_Tx_Cnt, in, 8, SPI master loaded-byte count.
- o_StatusReg, out, 8, control to the SPI master: bit0 reset, bit1 data, bit2 receive, bit3 send.
- o_TxBuffer, out, 8, byte to load.
- o_Cmd_Lim, out, 8, equal to BYTES_PER_CMD.
- o_Cmd_Idx, out, 3, current command.
- o_Busy, out, 1, sequence in progress.
- o_Done, out, 1, one-cycle pulse at sequence end.
- o_Error, out, 1, sticky timeout flag.

Function
REQ-003 States SHALL be: IDLE, RST, LOAD, LOAD_WAIT, SEND, WAIT_DONE, GAP, FINISH.
REQ-004 IDLE: i_Start=1 with i_Num_Cmds>0 SHALL go to RST, clear o_Error, set cmd index=0 and byte index=0, and set o_Busy=1.
REQ-005 IDLE: i_Start with i_Num_Cmds=0 SHALL pulse o_Done the next cycle and stay in IDLE.
REQ-006 RST SHALL drive o_StatusReg=0x01 for exactly one cycle, then go to LOAD.
REQ-007 LOAD SHALL drive o_TxBuffer with byte[byte index] (byte 0 = bits[23:16]) and o_StatusReg bit1=1 for exactly one cycle, and SHALL latch expected count = i_Tx_Cnt+1 (mod 256).
REQ-008 o_TxBuffer SHALL be held stable from the LOAD cycle until the next LOAD.
REQ-009 LOAD_WAIT SHALL keep o_StatusReg=0x00 until i_Tx_Cnt equals the expected count.
REQ-010 In LOAD_WAIT, when byte index < BYTES_PER_CMD-1, it SHALL increment byte index and go to LOAD; otherwise it SHALL go to SEND.
REQ-011 SEND SHALL drive o_StatusReg bit3=1, with bit2 equal to the command's receive flag, for exactly one cycle, then go to WAIT_DONE.
REQ-012 WAIT_DONE SHALL hold o_StatusReg bit2 = receive flag, and SHALL leave when i_SPI_StatusReg[7]=1 and i_SPI_StatusRW=1, but not in the first cycle after SEND.
REQ-013 On leaving WAIT_DONE: if cmd index = i_Num_Cmds-1, go to FINISH; otherwise go to GAP.
REQ-014 GAP SHALL count GAP_CYCLES cycles, then increment cmd index, clear byte index, and go to LOAD.
REQ-015 FINISH SHALL pulse o_Done for one cycle, clear o_Busy, and return to IDLE.
REQ-016 A wait counter SHALL clear on every state entry; in LOAD_WAIT or WAIT_DONE, reaching TIMEOUT SHALL set o_Error=1, drive o_StatusReg=0x01 for one cycle, and go to IDLE without asserting o_Done.
REQ-017 i_Start SHALL be ignored while o_Busy=1.
REQ-018 Table writes SHALL be accepted in every state; a write to the active entry mid-frame takes effect at the next LOAD.
REQ-019 o_Cmd_Lim SHALL always equal BYTES_PER_CMD; o_Cmd_Idx SHALL equal the cmd index.
REQ-020 i_Num_Cmds > NUM_CMDS SHALL be clamped to NUM_CMDS.

Reset
REQ-021 When i_Rst_n=0, the block SHALL immediately enter IDLE with o_StatusReg=0x00, o_TxBuffer=0x00, o_Cmd_Idx=0, o_Busy=0, o_Done=0, o_Error=0, and all counters=0.
REQ-022 Command table contents SHALL be reset to zero.
REQ-023 Reset asserted mid-sequence SHALL abort the sequence with no o_Done.
REQ-024 After reset deasserts, the first active clock edge SHALL be the first cycle in which the state machine may advance.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Table[0]=0x0A1234, i_Num_Cmds=1, i_Start, SPI master model -> o_StatusReg sequence 0x01, 0x02 (Tx 0x0A), 0x02 (0x12), 0x02 (0x34), 0x08; then o_Done pulses once after i_SPI_StatusReg=0x80 and i_SPI_StatusRW=1.
- Three commands -> exactly 21 idle cycles between each WAIT_DONE exit and the next LOAD; o_Cmd_Idx steps 0,1,2; one o_Done.
- Receive flag set -> o_StatusReg=0x0C on the SEND cycle and 0x04 during WAIT_DONE.
- i_Tx_Cnt frozen -> o_Error=1 after TIMEOUT cycles, one 0x01 pulse on o_StatusReg, o_Busy=0, no o_Done.
- i_Rst_n low during LOAD_WAIT -> all outputs at reset values within the same cycle; a later i_Start rerun succeeds.
- i_Start while busy, and i_Num_Cmds=0 -> the first is ignored; the second gives o_Done one cycle later with no o_StatusReg activity.
